// File: rtl/ltl_report_collector.sv
// Collects non-zero automaton report vectors, tags each with the symbol index it fired on,
// and queues the records in a FIFO for a ready/valid consumer; signals end of stream with done.
module ltl_report_collector #(
  parameter int N_REPORTS = 4,
  parameter int CNT_W     = 16,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [N_REPORTS-1:0]       report_in,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [CNT_W+N_REPORTS-1:0] rec_data,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int RW = CNT_W + N_REPORTS;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  sym_idx_q, sym_idx_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_count_q, drop_count_d;
  logic [RW-1:0]     mem_q [DEPTH];

  logic head_valid, full, push_req, push, pop, drop, done_c;

  always_comb begin
    head_valid = (occ_q != '0);
    full       = (occ_q == OW'(DEPTH));
    pop        = head_valid & rec_ready;
    push_req   = run & (|report_in);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push       = push_req & (~full | pop);
    drop       = push_req & ~push;

    sym_idx_d    = run  ? sym_idx_q + CNT_W'(1) : sym_idx_q;
    wr_ptr_d     = push ? wr_ptr_q + AW'(1)     : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1)     : rd_ptr_q;
    occ_d        = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    overflow_d   = overflow_q | drop;
    drop_count_d = (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
  end

  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE:   if (run) state_d = ACTIVE;
      ACTIVE: if (!run) state_d = DRAIN;
      DRAIN: begin
        if (run) begin
          state_d = ACTIVE;
        end else if (occ_q == '0) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sym_idx_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sym_idx_q    <= sym_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // NOTE: storage is not reset; occupancy gates visibility, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= {sym_idx_q, report_in};
  end

  // Outputs are forced low while reset is held, including the first reset cycle.
  assign rec_valid  = ~reset & head_valid;
  assign rec_data   = rec_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow   = ~reset & overflow_q;
  assign drop_count = reset ? 8'd0 : drop_count_q;
  assign done       = ~reset & done_c;

endmodule

// File: tb/tb_ltl_report_collector.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed
// scenarios with hand-computed expectations and a narrow-counter wrap instance.
module tb_ltl_report_collector;

  localparam int CW    = 16;
  localparam int DEPTH = 8;
  localparam int RW    = CW + 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic [3:0]    report_in = '0;
  logic          rec_ready = 1'b0;
  logic          rec_valid;
  logic [RW-1:0] rec_data;
  logic          overflow;
  logic [7:0]    drop_count;
  logic          done;

  logic          reset_w = 1'b1;
  logic          run_w = 1'b0;
  logic [3:0]    report_w = '0;
  logic          ready_w = 1'b0;
  logic          rec_valid_w;
  logic [7:0]    rec_data_w;
  logic          overflow_w;
  logic [7:0]    drop_count_w;
  logic          done_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ltl_report_collector #(.N_REPORTS(4), .CNT_W(CW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .run(run), .report_in(report_in),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .overflow(overflow), .drop_count(drop_count), .done(done)
  );

  ltl_report_collector #(.N_REPORTS(4), .CNT_W(4), .DEPTH(8)) dut_w (
    .clk(clk), .reset(reset_w), .run(run_w), .report_in(report_w),
    .rec_valid(rec_valid_w), .rec_ready(ready_w), .rec_data(rec_data_w),
    .overflow(overflow_w), .drop_count(drop_count_w), .done(done_w)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] mk(input int s, input logic [3:0] r);
    logic [31:0] sv;
    sv = s;
    return {sv[CW-1:0], r};
  endfunction

  // Reference model: a queue of records plus stream bookkeeping.
  logic [RW-1:0] mq[$];
  int            m_sidx = 0;
  bit            m_ovf = 0;
  int            m_drops = 0;
  bit            m_stream = 0;
  bit            m_last_run = 0;
  bit            e_valid, e_done, m_pop, m_full, m_push;
  logic [RW-1:0] e_data;

  always @(negedge clk) begin
    e_valid = !reset && mq.size() > 0;
    e_data  = e_valid ? mq[0] : '0;
    // End of stream: a stream was running, the previous cycle was already idle, still idle, nothing left.
    e_done  = !reset && m_stream && !m_last_run && !run && mq.size() == 0;
    check("m_rec_valid", rec_valid, e_valid);
    check("m_rec_data", rec_data, e_data);
    check("m_overflow", overflow, reset ? 1'b0 : m_ovf);
    check("m_drop_count", drop_count, reset ? 0 : m_drops);
    check("m_done", done, e_done);
    if (reset) begin
      mq.delete();
      m_sidx = 0; m_ovf = 0; m_drops = 0; m_stream = 0; m_last_run = 0;
    end else begin
      m_full = mq.size() == DEPTH;
      m_pop  = e_valid && rec_ready;
      m_push = run && report_in != 0;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (!m_full || m_pop) mq.push_back(mk(m_sidx, report_in));
        else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (run) m_sidx = (m_sidx + 1) % 65536;
      if (e_done) m_stream = 0;
      else if (run) m_stream = 1;
      m_last_run = run;
    end
  end

  task automatic set_in(input bit r, input logic [3:0] rep, input bit rdy);
    run = r; report_in = rep; rec_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_in(0, 4'd0, 0);
    reset = 1'b1;
    tick();
    #1;
    check("rst_valid", rec_valid, 1'b0);
    check("rst_data", rec_data, '0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drop_count", drop_count, 8'd0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
  endtask

  logic [3:0] got_w[$];
  bit         seq_run[5] = '{0, 0, 1, 0, 0};
  bit         seq_done[5] = '{0, 0, 0, 0, 1};

  initial begin
    int n;
    logic [RW-1:0] last;

    tick();
    do_reset();

    // Single report on cycle 3 surfaces on cycle 4 only.
    for (int i = 0; i < 12; i++) begin
      set_in(i < 10, (i == 3) ? 4'b0010 : 4'b0000, 1);
      #1;
      check("s1_valid", rec_valid, i == 4);
      if (i == 4) check("s1_data", rec_data, mk(3, 4'b0010));
      tick();
    end

    // Overflow: 10 pushes into depth 8 with the consumer stalled.
    do_reset();
    for (int i = 0; i < 10; i++) begin set_in(1, 4'b0001, 0); tick(); end
    set_in(0, 4'd0, 0);
    #1;
    check("s2_overflow", overflow, 1'b1);
    check("s2_drop_count", drop_count, 8'd2);
    check("s2_valid", rec_valid, 1'b1);
    for (int i = 0; i < 8; i++) begin
      set_in(0, 4'd0, 1);
      #1;
      check("s2_order", rec_data, mk(i, 4'b0001));
      tick();
    end
    #1;
    check("s2_empty", rec_valid, 1'b0);

    // Full FIFO with a pop and a push in the same cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin set_in(1, 4'b0001, 0); tick(); end
    set_in(1, 4'b0100, 1);
    #1;
    check("s3_head", rec_data, mk(0, 4'b0001));
    tick();
    set_in(0, 4'd0, 0);
    #1;
    check("s3_drop_count", drop_count, 8'd0);
    check("s3_overflow", overflow, 1'b0);
    check("s3_head2", rec_data, mk(1, 4'b0001));
    n = 0;
    last = '0;
    for (int k = 0; k < 12; k++) begin
      set_in(0, 4'd0, 1);
      #1;
      if (rec_valid) begin n++; last = rec_data; end
      tick();
    end
    check("s3_occupancy", n, 8);
    check("s3_last", last, mk(8, 4'b0100));

    // Drain then done; then a run reassertion during DRAIN suppresses done.
    do_reset();
    for (int i = 0; i < 3; i++) begin set_in(1, 4'b0001, 0); tick(); end
    for (int i = 0; i < 6; i++) begin
      set_in(0, 4'd0, 1);
      #1;
      check("s4_done", done, i == 3);
      tick();
    end
    for (int i = 0; i < 2; i++) begin set_in(1, 4'b0001, 0); tick(); end
    for (int i = 0; i < 5; i++) begin
      set_in(seq_run[i], 4'd0, 1);
      #1;
      check("s4_redone", done, seq_done[i]);
      tick();
    end

    // Mid-stream reset discards the queue and restarts the index.
    do_reset();
    for (int i = 0; i < 10; i++) begin set_in(1, 4'b0001, 0); tick(); end
    for (int i = 0; i < 3; i++) begin set_in(0, 4'd0, 1); tick(); end
    #1;
    check("s5_pre_overflow", overflow, 1'b1);
    reset = 1'b1;
    set_in(0, 4'd0, 0);
    tick();
    reset = 1'b0;
    set_in(1, 4'b1000, 0);
    #1;
    check("s5_valid", rec_valid, 1'b0);
    check("s5_overflow", overflow, 1'b0);
    check("s5_drop_count", drop_count, 8'd0);
    tick();
    set_in(0, 4'd0, 0);
    #1;
    check("s5_first_push", rec_data, mk(0, 4'b1000));

    // Randomized traffic, including a long stall that saturates drop_count.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c == 1900) check("rnd_saturate", drop_count, 8'd255);
      if (c >= 1500 && c < 1900) begin
        reset = 1'b0;
        set_in(1, 4'($urandom_range(1, 15)), 0);
      end else begin
        reset = ($urandom_range(0, 999) == 0);
        set_in($urandom_range(0, 9) < 7,
               ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
               $urandom_range(0, 3) != 0);
      end
      tick();
    end
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin set_in(0, 4'd0, 1); tick(); end

    // Counter wrap on the 4-bit instance.
    reset_w = 1'b1;
    tick();
    reset_w = 1'b0;
    for (int i = 0; i < 21; i++) begin
      run_w = (i < 20); report_w = (i < 20) ? 4'b0001 : 4'b0000; ready_w = 1'b1;
      #1;
      if (rec_valid_w) got_w.push_back(rec_data_w[7:4]);
      tick();
    end
    check("wrap_count", got_w.size(), 20);
    for (int k = 0; k < got_w.size() && k < 20; k++) check("wrap_idx", got_w[k], k % 16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
